// File: rtl/adder_regs_pkg.sv
// Register map, response codes, status encodings and FSM states shared by the
// adder peripheral and its AXI4-Lite client.
package adder_regs_pkg;

  localparam int unsigned ADDR_OPA = 32'h0;
  localparam int unsigned ADDR_OPB = 32'h4;
  localparam int unsigned ADDR_SUM = 32'h8;
  localparam int unsigned ADDR_OVF = 32'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RESP    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_A,
    S_WRESP_A,
    S_WR_B,
    S_WRESP_B,
    S_RD_SUM,
    S_RDATA_SUM,
    S_RD_OVF,
    S_RDATA_OVF,
    S_DONE
  } state_t;

  // States in which the handshake watchdog runs.
  function automatic logic is_active(state_t s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

endpackage

// File: rtl/adder_client_if.sv
// AXI4-Lite bus between the adder client (master) and the adder peripheral (slave).
interface adder_client_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/adder_client.sv
// AXI4-Lite master running one add operation on the adder peripheral per start:
// write A, write B, read sum, read overflow, then report status to local logic.
module adder_client
  import adder_regs_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 256
) (
  input  logic                  m1_axi_aclk,
  input  logic                  m1_axi_areset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  overflow,
  output logic [1:0]            err,
  adder_client_if.master        m1_axi
);

  localparam int unsigned WD_WIDTH = $clog2(TIMEOUT_CYCLES + 2);
  localparam bit          WD_ON    = (TIMEOUT_CYCLES != 0);

  localparam logic [ADDR_WIDTH-1:0] A_OPA = BASE_ADDR + ADDR_WIDTH'(ADDR_OPA);
  localparam logic [ADDR_WIDTH-1:0] A_OPB = BASE_ADDR + ADDR_WIDTH'(ADDR_OPB);
  localparam logic [ADDR_WIDTH-1:0] A_SUM = BASE_ADDR + ADDR_WIDTH'(ADDR_SUM);
  localparam logic [ADDR_WIDTH-1:0] A_OVF = BASE_ADDR + ADDR_WIDTH'(ADDR_OVF);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, opb_q, opb_d, sum_q, sum_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                  bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  ovf_q, ovf_d, done_q, done_d, busy_q, busy_d;
  logic [1:0]            err_q, err_d;
  logic [WD_WIDTH-1:0]   wd_q, wd_d, wd_inc;
  logic                  aw_ok, w_ok;

  // A write channel counts as complete once its valid is down or is being accepted now.
  assign aw_ok  = !awvalid_q || m1_axi.awready;
  assign w_ok   = !wvalid_q  || m1_axi.wready;
  assign wd_inc = wd_q + WD_WIDTH'(1);

  always_ff @(posedge m1_axi_aclk) begin
    if (m1_axi_areset) begin
      state_q   <= S_IDLE;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      opb_q     <= '0;
      sum_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= ERR_OK;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      opb_q     <= opb_d;
      sum_q     <= sum_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
    end
  end

  // Next-state logic; every output register is loaded with the value for the next cycle.
  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    opb_d     = opb_q;
    sum_d     = sum_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q;
    wd_d      = wd_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WR_A;
          busy_d    = 1'b1;
          err_d     = ERR_OK;
          opb_d     = op_b;
          awaddr_d  = A_OPA;
          wdata_d   = op_a;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      S_WR_A, S_WR_B: begin
        if (awvalid_q && m1_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m1_axi.wready)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          state_d  = (state_q == S_WR_A) ? S_WRESP_A : S_WRESP_B;
          bready_d = 1'b1;
        end
      end
      S_WRESP_A, S_WRESP_B: begin
        if (m1_axi.bvalid) begin
          bready_d = 1'b0;
          if (m1_axi.bresp != RESP_OKAY) begin
            err_d   = ERR_RESP;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (state_q == S_WRESP_A) begin
            state_d   = S_WR_B;
            awaddr_d  = A_OPB;
            wdata_d   = opb_q;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_SUM;
            araddr_d  = A_SUM;
            arvalid_d = 1'b1;
          end
        end
      end
      S_RD_SUM, S_RD_OVF: begin
        if (m1_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = (state_q == S_RD_SUM) ? S_RDATA_SUM : S_RDATA_OVF;
        end
      end
      S_RDATA_SUM, S_RDATA_OVF: begin
        if (m1_axi.rvalid) begin
          rready_d = 1'b0;
          if (m1_axi.rresp != RESP_OKAY) begin
            err_d   = ERR_RESP;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (state_q == S_RDATA_SUM) begin
            sum_d     = m1_axi.rdata;
            state_d   = S_RD_OVF;
            araddr_d  = A_OVF;
            arvalid_d = 1'b1;
          end else begin
            ovf_d   = m1_axi.rdata[0];
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog: a stalled handshake abandons the operation with a timeout status.
    if (WD_ON && is_active(state_q) && (state_d == state_q) &&
        (wd_inc == WD_WIDTH'(TIMEOUT_CYCLES))) begin
      state_d   = S_DONE;
      done_d    = 1'b1;
      err_d     = ERR_TIMEOUT;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
    end

    if (state_d != state_q)   wd_d = '0;
    else if (is_active(state_q)) wd_d = wd_inc;
  end

  assign m1_axi.awaddr  = awaddr_q;
  assign m1_axi.awvalid = awvalid_q;
  assign m1_axi.wdata   = wdata_q;
  assign m1_axi.wstrb   = '1;
  assign m1_axi.wvalid  = wvalid_q;
  assign m1_axi.bready  = bready_q;
  assign m1_axi.araddr  = araddr_q;
  assign m1_axi.arvalid = arvalid_q;
  assign m1_axi.rready  = rready_q;

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign overflow = ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_adder_client.sv
// Bench for adder_client: reactive AXI-Lite adder slave with per-channel delays and
// error injection, transaction scoreboard, and one task per scenario.
module tb_adder_client;
  import adder_regs_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start;
  logic [DW-1:0] op_a, op_b;
  logic          busy, done, overflow;
  logic [DW-1:0] sum;
  logic [1:0]    err;

  adder_client_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_axi ();

  adder_client #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(8'h00), .TIMEOUT_CYCLES(16)
  ) dut (
    .m1_axi_aclk(clk), .m1_axi_areset(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .sum(sum), .overflow(overflow), .err(err), .m1_axi(m1_axi)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Slave configuration and state
  int          aw_delay = 0, w_delay = 0;
  bit          ar_block = 0, werr_en = 0;
  logic [7:0]  werr_addr = 8'h00;
  bit          aw_got, w_got, b_pend, r_pend;
  logic [7:0]  aw_addr_l;
  logic [31:0] w_data_l, r_data_p, reg_a, reg_b;
  logic [1:0]  b_resp_p;
  logic [32:0] s33;
  int          aw_cnt, w_cnt, aw_hi, w_hi, ar_hi;

  // Adder peripheral model: decides ready/valid at negedge for the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      m1_axi.awready = 0; m1_axi.wready = 0; m1_axi.bvalid = 0; m1_axi.bresp = RESP_OKAY;
      m1_axi.arready = 0; m1_axi.rvalid = 0; m1_axi.rresp = RESP_OKAY; m1_axi.rdata = '0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0;
      reg_a = '0; reg_b = '0;
    end else begin
      m1_axi.bvalid = b_pend;
      m1_axi.bresp  = b_resp_p;
      if (b_pend && m1_axi.bready) b_pend = 0;
      m1_axi.rvalid = r_pend;
      m1_axi.rdata  = r_data_p;
      if (r_pend && m1_axi.rready) r_pend = 0;

      m1_axi.awready = 0;
      if (m1_axi.awvalid) begin
        aw_hi++;
        if (aw_cnt >= aw_delay) begin
          m1_axi.awready = 1; aw_got = 1; aw_addr_l = m1_axi.awaddr; aw_cnt = 0;
        end else aw_cnt++;
      end
      m1_axi.wready = 0;
      if (m1_axi.wvalid) begin
        w_hi++;
        if (w_cnt >= w_delay) begin
          m1_axi.wready = 1; w_got = 1; w_data_l = m1_axi.wdata; w_cnt = 0;
        end else w_cnt++;
      end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0;
        obs_q.push_back('{rd: 1'b0, addr: aw_addr_l, data: w_data_l});
        if (aw_addr_l == 8'(ADDR_OPA)) reg_a = w_data_l;
        if (aw_addr_l == 8'(ADDR_OPB)) reg_b = w_data_l;
        b_resp_p = (werr_en && aw_addr_l == werr_addr) ? RESP_SLVERR : RESP_OKAY;
        b_pend   = 1;
      end

      m1_axi.arready = 0;
      if (m1_axi.arvalid) begin
        ar_hi++;
        if (!ar_block) begin
          m1_axi.arready = 1;
          obs_q.push_back('{rd: 1'b1, addr: m1_axi.araddr, data: 32'h0});
          s33 = {1'b0, reg_a} + {1'b0, reg_b};
          r_data_p = (m1_axi.araddr == 8'(ADDR_OVF)) ? {31'h0, s33[32]} : s33[31:0];
          r_pend = 1;
        end
      end
    end
  end

  task automatic expect_op(input logic [31:0] a, input logic [31:0] b, input int n);
    txn_t t[4];
    t[0] = '{rd: 1'b0, addr: 8'(ADDR_OPA), data: a};
    t[1] = '{rd: 1'b0, addr: 8'(ADDR_OPB), data: b};
    t[2] = '{rd: 1'b1, addr: 8'(ADDR_SUM), data: 32'h0};
    t[3] = '{rd: 1'b1, addr: 8'(ADDR_OVF), data: 32'h0};
    for (int i = 0; i < n; i++) exp_q.push_back(t[i]);
  endtask

  // Runs one operation; returns the cycle (1 = first after accept) in which done rose.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int pulse_k,
                       output int done_k, output int busy_n);
    int k;
    aw_hi = 0; w_hi = 0; ar_hi = 0;
    @(negedge clk); start = 1; op_a = a; op_b = b;
    @(posedge clk);
    @(negedge clk);
    k = 1; done_k = -1; busy_n = 0;
    while (done_k < 0 && k <= 64) begin
      start = (k == pulse_k);
      if (k == pulse_k) begin op_a = ~a; op_b = 32'h1234; end
      busy_n += busy ? 1 : 0;
      if (done) done_k = k;
      else begin @(negedge clk); k++; end
    end
    start = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({m1_axi.awvalid, m1_axi.wvalid, m1_axi.bready, m1_axi.arvalid, m1_axi.rready} !== 5'b0) begin
      n_errors++; $display("FAIL reset_handshake: got %b, expected 00000",
        {m1_axi.awvalid, m1_axi.wvalid, m1_axi.bready, m1_axi.arvalid, m1_axi.rready});
    end
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_errors++; $display("FAIL reset_busy_done: got %b, expected 00", {busy, done});
    end
    n_checks++;
    if (err !== ERR_OK) begin n_errors++; $display("FAIL reset_err: got %b, expected 00", err); end
    n_checks++;
    if (sum !== 32'h0) begin n_errors++; $display("FAIL reset_sum: got %h, expected 0", sum); end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b, expected 0", overflow); end
    n_checks++;
    if ({m1_axi.awaddr, m1_axi.araddr, m1_axi.wdata} !== 48'h0) begin
      n_errors++; $display("FAIL reset_addr_data: got %h, expected 0",
        {m1_axi.awaddr, m1_axi.araddr, m1_axi.wdata});
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    int dk, bn; txn_t e, o;
    expect_op(32'd5, 32'd7, 4);
    do_op(32'd5, 32'd7, 0, dk, bn);
    n_checks++; if (dk !== 9) begin n_errors++; $display("FAIL zw_done_cycle: got %0d, expected 9", dk); end
    n_checks++; if (bn !== 9) begin n_errors++; $display("FAIL zw_busy_cycles: got %0d, expected 9", bn); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL zw_busy_after: got %b, expected 0", busy); end
    n_checks++; if (sum !== 32'd12) begin n_errors++; $display("FAIL zw_sum: got %0d, expected 12", sum); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL zw_ovf: got %b, expected 0", overflow); end
    n_checks++; if (err !== ERR_OK) begin n_errors++; $display("FAIL zw_err: got %b, expected 00", err); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_errors++; $display("FAIL zw_txn_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL zw_txn: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_aw_delay();
    int dk, bn; txn_t e, o;
    aw_delay = 3;
    expect_op(32'd100, 32'd23, 4);
    do_op(32'd100, 32'd23, 0, dk, bn);
    aw_delay = 0;
    n_checks++; if (dk !== 15) begin n_errors++; $display("FAIL awd_done_cycle: got %0d, expected 15", dk); end
    n_checks++; if (aw_hi !== 8) begin n_errors++; $display("FAIL awd_awvalid_cycles: got %0d, expected 8", aw_hi); end
    n_checks++; if (w_hi !== 2) begin n_errors++; $display("FAIL awd_wvalid_cycles: got %0d, expected 2", w_hi); end
    n_checks++; if (sum !== 32'd123) begin n_errors++; $display("FAIL awd_sum: got %0d, expected 123", sum); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_errors++; $display("FAIL awd_txn_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL awd_txn: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_write_error();
    int dk, bn; txn_t e, o;
    werr_en = 1; werr_addr = 8'(ADDR_OPB);
    expect_op(32'd8, 32'd9, 2);
    do_op(32'd8, 32'd9, 0, dk, bn);
    werr_en = 0;
    n_checks++; if (dk !== 5) begin n_errors++; $display("FAIL werr_done_cycle: got %0d, expected 5", dk); end
    n_checks++; if (err !== ERR_RESP) begin n_errors++; $display("FAIL werr_err: got %b, expected 01", err); end
    n_checks++; if (ar_hi !== 0) begin n_errors++; $display("FAIL werr_no_ar: got %0d, expected 0", ar_hi); end
    n_checks++; if (sum !== 32'd123) begin n_errors++; $display("FAIL werr_sum_held: got %0d, expected 123", sum); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_errors++; $display("FAIL werr_txn_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL werr_txn: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    int dk, bn; txn_t e, o;
    ar_block = 1;
    expect_op(32'd1, 32'd1, 2);
    do_op(32'd1, 32'd1, 0, dk, bn);
    ar_block = 0;
    n_checks++; if (dk !== 21) begin n_errors++; $display("FAIL to_done_cycle: got %0d, expected 21", dk); end
    n_checks++; if (err !== ERR_TIMEOUT) begin n_errors++; $display("FAIL to_err: got %b, expected 10", err); end
    n_checks++; if (ar_hi !== 16) begin n_errors++; $display("FAIL to_arvalid_cycles: got %0d, expected 16", ar_hi); end
    n_checks++; if (m1_axi.arvalid !== 1'b0) begin n_errors++; $display("FAIL to_arvalid_after: got %b, expected 0", m1_axi.arvalid); end
    n_checks++; if (sum !== 32'd123) begin n_errors++; $display("FAIL to_sum_held: got %0d, expected 123", sum); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_errors++; $display("FAIL to_txn_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL to_txn: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow();
    int dk, bn;
    expect_op(32'hFFFF_FFFF, 32'h1, 4);
    do_op(32'hFFFF_FFFF, 32'h1, 0, dk, bn);
    n_checks++; if (dk !== 9) begin n_errors++; $display("FAIL ovf_done_cycle: got %0d, expected 9", dk); end
    n_checks++; if (sum !== 32'h0) begin n_errors++; $display("FAIL ovf_sum: got %h, expected 0", sum); end
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b, expected 1", overflow); end
    n_checks++; if (err !== ERR_OK) begin n_errors++; $display("FAIL ovf_err: got %b, expected 00", err); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_errors++; $display("FAIL ovf_txn_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_start_busy_reset();
    int dk, bn, k; bit seen; txn_t e, o;
    expect_op(32'd11, 32'd22, 4);
    do_op(32'd11, 32'd22, 3, dk, bn);
    n_checks++; if (dk !== 9) begin n_errors++; $display("FAIL sb_done_cycle: got %0d, expected 9", dk); end
    n_checks++; if (sum !== 32'd33) begin n_errors++; $display("FAIL sb_sum: got %0d, expected 33", sum); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL sb_ovf: got %b, expected 0", overflow); end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_errors++; $display("FAIL sb_txn_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL sb_txn: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();

    // Abandon an operation with reset while waiting for the sum read data.
    expect_op(32'd40, 32'd2, 3);
    @(negedge clk); start = 1; op_a = 32'd40; op_b = 32'd2;
    @(posedge clk);
    @(negedge clk); start = 0;
    seen = 0; k = 0;
    while (!seen && k < 20) begin
      if (m1_axi.rready) seen = 1; else begin @(negedge clk); k++; end
    end
    n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL rst_reach_rdata: got %b, expected 1", seen); end
    rst = 1;
    @(negedge clk);
    n_checks++; if (m1_axi.rready !== 1'b0) begin n_errors++; $display("FAIL rst_rready: got %b, expected 0", m1_axi.rready); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    n_checks++; if (dut.state_q !== S_IDLE) begin n_errors++; $display("FAIL rst_state: got %0d, expected %0d", dut.state_q, S_IDLE); end
    rst = 0;
    @(negedge clk);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_errors++; $display("FAIL rst_txn_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL rst_txn: got %h, expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();

    expect_op(32'd3, 32'd4, 4);
    do_op(32'd3, 32'd4, 0, dk, bn);
    n_checks++; if (dk !== 9) begin n_errors++; $display("FAIL rec_done_cycle: got %0d, expected 9", dk); end
    n_checks++; if (sum !== 32'd7) begin n_errors++; $display("FAIL rec_sum: got %0d, expected 7", sum); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_aw_delay();
    test_write_error();
    test_timeout();
    test_overflow();
    test_start_busy_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_client.md
# adder_client

AXI4-Lite master that drives the memory-mapped adder peripheral through one complete operation. On a single `start` pulse it performs four transactions in order:

- write operand A to offset 0x0;
- write operand B to offset 0x4;
- read the sum from offset 0x8;
- read the overflow flag from offset 0xC.

It then returns the sum, the overflow flag and an error status to the local logic. It sits between the local control logic and the peripheral's AXI-Lite slave port.

## Interface

- `DATA_WIDTH`, 32, AXI data width and operand width.
- `ADDR_WIDTH`, 8, AXI address width.
- `BASE_ADDR`, 0, peripheral base, added to every register offset.
- `TIMEOUT_CYCLES`, 256, maximum wait cycles per handshake; 0 disables the watchdog.

Ports (one clock; reset is synchronous and active-high):

- `m1_axi_aclk` in 1 — clock.
- `m1_axi_areset` in 1 — synchronous, active-high reset.
- `start` in 1 — begin an operation; sampled only in IDLE.
- `op_a`, `op_b` in DATA_WIDTH — operands, latched on accepted `start`.
- `busy` out 1 — high from the cycle after accept through DONE.
- `done` out 1 — one-cycle completion pulse.
- `sum` out DATA_WIDTH — captured read data from 0x8.
- `overflow` out 1 — bit 0 of the read data from 0xC.
- `err` out 2 — completion status: 00 OK, 01 non-OKAY response, 10 timeout.
- Write address: `m1_axi_awaddr` out ADDR_WIDTH, `m1_axi_awvalid` out 1, `m1_axi_awready` in 1.
- Write data: `m1_axi_wdata` out DATA_WIDTH, `m1_axi_wstrb` out DATA_WIDTH/8, `m1_axi_wvalid` out 1, `m1_axi_wready` in 1.
- Write response: `m1_axi_bresp` in 2, `m1_axi_bvalid` in 1, `m1_axi_bready` out 1.
- Read address: `m1_axi_araddr` out ADDR_WIDTH, `m1_axi_arvalid` out 1, `m1_axi_arready` in 1.
- Read data: `m1_axi_rdata` in DATA_WIDTH, `m1_axi_rresp` in 2, `m1_axi_rvalid` in 1, `m1_axi_rready` out 1.

## Operation

- **States:** IDLE, WR_A, WRESP_A, WR_B, WRESP_B, RD_SUM, RDATA_SUM, RD_OVF, RDATA_OVF, DONE.
- **IDLE:** on `start`=1, latch `op_a`/`op_b`, clear `err`, go to WR_A. Hold `sum`/`overflow`/`err` from the previous operation until then.
- **WR_x:**
  - Drive `awaddr`=BASE+offset, `wdata`=operand, `wstrb`=all ones, with `awvalid` and `wvalid` both high.
  - Each valid drops independently on the cycle after its own ready is seen. AW and W may complete in either order or in the same cycle.
  - Never re-issue a channel that has already completed.
  - Advance once both channels have completed.
- **WRESP_x:** `bready`=1. On `bvalid`:
  - `bresp`==00: advance.
  - otherwise: set `err`=01 and go to DONE; no further transactions are issued.
- **RD_x:** `arvalid`=1, `araddr`=BASE+offset. On `arready`, advance.
- **RDATA_x:** `rready`=1. On `rvalid`:
  - `rresp`==00: capture `sum`=`rdata` or `overflow`=`rdata[0]`, then advance.
  - otherwise: set `err`=01 and go to DONE.
- **Watchdog:**
  - A counter clears on every state entry and increments each cycle spent in any state other than IDLE and DONE.
  - When it reaches TIMEOUT_CYCLES (nonzero): deassert all valids and readies, set `err`=10, go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE. `start` is ignored in DONE and whenever `busy`=1.
- **Reset values:**
  - All `*valid`, `*ready`, `done`, `busy`, `overflow` = 0.
  - `err` = 00, `sum` = 0, addresses/data = 0.
  - State = IDLE.
- **Reset mid-operation:** all AXI outputs return to reset values at the next edge and the operation is abandoned. This is legal only because the peripheral shares this reset.

## Timing

- All outputs are registered; no combinational path from any input to any output.
- **Zero-wait slave** (ready/valid asserted in the first cycle offered), with `start` accepted at edge 0:
  - AW/W valid in cycle 1;
  - `bready` in cycle 2, B's writes in cycles 3–4;
  - AR for sum in cycle 5, R in cycle 6;
  - AR for overflow in cycle 7, R in cycle 8;
  - `done` in cycle 9.
- Each additional slave wait cycle adds exactly one cycle.
- `sum` is valid from cycle 7 and `overflow` from cycle 9. Both remain stable until the next accepted `start`.
- `busy` is high in cycles 1–9 inclusive.

## Structure

- Shared package `adder_regs_pkg`:
  - offsets ADDR_OPA=0x0, ADDR_OPB=0x4, ADDR_SUM=0x8, ADDR_OVF=0xC;
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - `err` encodings;
  - the state enum.
- No sub-module is required. Optionally, one `axil_wr_channel` sub-module can implement the AW/W handshake with per-channel completion flags; it is instantiated once and reused for both writes.

## Test plan

1. **Zero-wait slave:** A=5, B=7, slave returns sum 12 and overflow 0 → writes (0x0,5) then (0x4,7), reads 0x8 then 0xC; `sum`=12, `overflow`=0, `err`=00, `done` in cycle 9.
2. **Delayed AW ready:** `awready` delayed 3 cycles, `wready` immediate → `wvalid` high for 1 cycle only, `awvalid` high for 4 cycles, exactly one write per register.
3. **Write error:** `bresp`=10 on the operand-B write → no AR is ever issued; `done` pulse with `err`=01.
4. **Timeout:** TIMEOUT_CYCLES=16, `arready` held low → `arvalid` drops after 16 cycles in RD_SUM; `done` with `err`=10.
5. **Overflow:** A=0xFFFFFFFF, B=1, slave returns sum 0 and overflow 1 → `sum`=0, `overflow`=1.
6. **Start while busy, then reset:** `start` pulsed in cycle 3 → ignored, no extra transactions. Reset asserted during RDATA_SUM → `rready` and `busy` are 0 the next cycle and state is IDLE.
